// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, default LFSR
// shape (shared with the generator) and the feedback helper.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int PRBS_WIDTH = 4;
  localparam logic [PRBS_WIDTH-1:0] PRBS_TAPS = 4'b1101;

  function automatic logic lfsr_fb(
    input logic [31:0] state,
    input logic [31:0] taps
  );
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Sliding-block error window: counts valid bits and errors while
// locked and flags the bit that reaches the error threshold.
module prbs_err_window
  import prbs_pkg::*;
#(
  parameter int WIN    = 32,
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic err,
  output logic thresh_hit
);

  localparam int BW = $clog2(WIN + 1);
  localparam int EW = $clog2(THRESH + 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(WIN - 1);
  localparam logic [EW-1:0] ERRS_LAST = EW'(THRESH - 1);

  logic [BW-1:0] bits_q;
  logic [EW-1:0] errs_q;

  assign thresh_hit = en && err && (errs_q == ERRS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q <= '0;
      errs_q <= '0;
    end else if (clr) begin
      bits_q <= '0;
      errs_q <= '0;
    end else if (en) begin
      if (bits_q == BITS_LAST) begin
        bits_q <= '0;
        errs_q <= '0;
      end else begin
        bits_q <= bits_q + 1'b1;
        errs_q <= errs_q + EW'(err);
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with flywheel reference,
// lock detection, error pulses and a saturating error counter.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = PRBS_TAPS,
  parameter int LOCK_COUNT = 8,
  parameter int ERR_WINDOW = 32,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [SW-1:0] SEED_LAST = SW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);

  state_t state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [SW-1:0] seed_q, seed_d;
  logic [MW-1:0] match_q, match_d;
  logic exp_bit, mismatch;
  logic win_en, win_clr, thresh_hit;
  logic pulse_d;
  logic [CNT_W-1:0] cnt_d;

  assign exp_bit  = lfsr_fb(32'(ref_q), 32'(TAPS));
  assign mismatch = din ^ exp_bit;
  assign win_en   = din_valid && (state_q == LOCKED);
  assign win_clr  = (state_q != LOCKED);
  assign locked   = (state_q == LOCKED);

  prbs_err_window #(
    .WIN    (ERR_WINDOW),
    .THRESH (ERR_THRESH)
  ) u_win (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (win_en),
    .clr        (win_clr),
    .err        (mismatch),
    .thresh_hit (thresh_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
      ref_q   <= '0;
      seed_q  <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      seed_q  <= seed_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    seed_d  = seed_q;
    match_d = match_q;
    if (din_valid) begin
      unique case (state_q)
        SEED: begin
          ref_d = {din, ref_q[WIDTH-1:1]};
          if (seed_q == SEED_LAST) begin
            seed_d = '0;
            // an all-zero seed is a stuck line, keep seeding
            if (ref_d != '0) begin
              state_d = VERIFY;
              match_d = '0;
            end
          end else begin
            seed_d = seed_q + 1'b1;
          end
        end
        VERIFY: begin
          ref_d = {exp_bit, ref_q[WIDTH-1:1]};
          if (mismatch) begin
            state_d = SEED;
            seed_d  = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = LOCKED;
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        LOCKED: begin
          ref_d = {exp_bit, ref_q[WIDTH-1:1]};
          if (thresh_hit) begin
            state_d = SEED;
            seed_d  = '0;
          end
        end
        default: begin
          state_d = SEED;
          seed_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pulse_d = win_en && mismatch;
    cnt_d   = err_count;
    if (clear) begin
      cnt_d = '0;
    end else if (pulse_d && (err_count != '1)) begin
      cnt_d = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= pulse_d;
      err_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed scenarios plus random stream
// errors, checked every cycle against a recurrence-based model.
module tb_prbs_checker;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clear = 1'b0;
  logic locked;
  logic err_pulse;
  logic [CW-1:0] err_count;

  int nchecks = 0;
  int nerrors = 0;

  prbs_checker #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // model: 0 seeding, 1 verifying, 2 locked
  int m_mode;
  bit hist[$];
  int m_nseed, m_nmatch, m_wbits, m_werrs, m_cnt;
  bit m_pulse;

  task automatic check(input string name, input int act,
                       input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, want %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    hist.delete();
    repeat (4) hist.push_back(1'b0);
    m_nseed = 0;
    m_nmatch = 0;
    m_wbits = 0;
    m_werrs = 0;
    m_cnt = 0;
    m_pulse = 0;
  endtask

  // reference bits obey b[n+4] = b[n+3]^b[n+2]^b[n]
  task automatic model_step(input bit d, input bit v,
                            input bit c);
    bit e;
    m_pulse = 0;
    if (v) begin
      if (m_mode == 0) begin
        hist.push_back(d);
        void'(hist.pop_front());
        m_nseed++;
        if (m_nseed == 4) begin
          m_nseed = 0;
          if (hist[0] | hist[1] | hist[2] | hist[3]) begin
            m_mode = 1;
            m_nmatch = 0;
          end
        end
      end else begin
        e = hist[3] ^ hist[2] ^ hist[0];
        hist.push_back(e);
        void'(hist.pop_front());
        if (m_mode == 1) begin
          if (d != e) begin
            m_mode = 0;
            m_nseed = 0;
          end else begin
            m_nmatch++;
            if (m_nmatch == 8) begin
              m_mode = 2;
              m_wbits = 0;
              m_werrs = 0;
            end
          end
        end else begin
          m_wbits++;
          if (d != e) begin
            m_pulse = 1;
            m_werrs++;
            if (m_cnt < CMAX) m_cnt++;
          end
          if (m_werrs == 4) begin
            m_mode = 0;
            m_nseed = 0;
          end else if (m_wbits == 32) begin
            m_wbits = 0;
            m_werrs = 0;
          end
        end
      end
    end
    if (c) m_cnt = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(din, din_valid, clear);
    #1;
    check("locked", int'(locked), int'(m_mode == 2));
    check("err_pulse", int'(err_pulse), int'(m_pulse));
    check("err_count", int'(err_count), m_cnt);
  end

  logic [3:0] g;

  task automatic tick(input bit d, input bit v, input bit c);
    din = d;
    din_valid = v;
    clear = c;
    @(posedge clk);
    #2;
  endtask

  task automatic gen(input bit inv, input bit v, input bit c);
    tick(g[0] ^ inv, v, c);
    if (v) g = {^(g & 4'b1101), g[3:1]};
  endtask

  task automatic gen_n(input int n);
    repeat (n) gen(1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int rate;
    bit v, inv, c;
    g = 4'b0001;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("rst_locked", int'(locked), 0);
    check("rst_pulse", int'(err_pulse), 0);
    check("rst_count", int'(err_count), 0);

    // clean stream from seed 0001
    gen_n(11);
    check("t1_prelock", int'(locked), 0);
    gen_n(1);
    check("t1_lock", int'(locked), 1);
    gen_n(188);
    check("t1_count", int'(err_count), 0);
    check("t1_locked", int'(locked), 1);

    // single inverted bit
    gen(1'b1, 1'b1, 1'b0);
    check("t2_pulse", int'(err_pulse), 1);
    check("t2_count", int'(err_count), 1);
    gen_n(1);
    check("t2_pulse_end", int'(err_pulse), 0);
    gen_n(40);
    check("t2_count_hold", int'(err_count), 1);
    check("t2_locked", int'(locked), 1);

    // asynchronous reset while locked
    #3;
    rst_n = 1'b0;
    #1;
    check("async_locked", int'(locked), 0);
    check("async_count", int'(err_count), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // four errors inside one window
    gen_n(12);
    check("t3_lock", int'(locked), 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) gen_n(4);
      gen(1'b1, 1'b1, 1'b0);
    end
    check("t3_unlock", int'(locked), 0);
    check("t3_count", int'(err_count), 4);
    gen_n(11);
    check("t3_prelock", int'(locked), 0);
    gen_n(1);
    check("t3_relock", int'(locked), 1);

    // clear coinciding with an error
    gen(1'b1, 1'b1, 1'b1);
    check("t6_count", int'(err_count), 0);
    check("t6_pulse", int'(err_pulse), 1);

    // stuck-at-zero line
    do_reset();
    repeat (60) tick(1'b0, 1'b1, 1'b0);
    check("t4_locked", int'(locked), 0);
    check("t4_count", int'(err_count), 0);

    // valid toggling 1,0,1,0
    do_reset();
    for (int i = 0; i < 23; i++) begin
      gen(1'b0, (i % 2) == 0, 1'b0);
      if (i == 21) check("t5_prelock", int'(locked), 0);
    end
    check("t5_lock", int'(locked), 1);

    // random errors, gaps and clears
    for (int p = 0; p < 8; p++) begin
      case (p % 4)
        0: rate = 0;
        1: rate = 2;
        2: rate = 8;
        default: rate = 25;
      endcase
      repeat (400) begin
        v = ($urandom_range(0, 9) != 0);
        inv = ($urandom_range(0, 99) < rate);
        c = ($urandom_range(0, 59) == 0);
        gen(inv, v, c);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
